// File: rtl/hsqrt_arbiter_if.sv
// +------------------------------------------------------------------+
// | hsqrt_arbiter_if: requester, sqrt-unit and response signal bundle  |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

interface hsqrt_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [16*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [15:0]          sq_din;
  logic [7:0]           sq_dout;
  logic [NREQ-1:0]      rsp_valid;
  logic [7:0]           rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic [3:0]           inflight;

  // master: requesters plus the sqrt unit; slave: the arbiter itself
  modport master (
    output req_valid, req_data, sq_dout,
    input  req_ready, sq_din, rsp_valid, rsp_data, rsp_id, inflight
  );
  modport slave (
    input  req_valid, req_data, sq_dout,
    output req_ready, sq_din, rsp_valid, rsp_data, rsp_id, inflight
  );
endinterface

`default_nettype wire

// File: rtl/hsqrt_arbiter.sv
// +------------------------------------------------------------------+
// | hsqrt_arbiter: round-robin share of one pipelined 16->8 sqrt unit  |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module hsqrt_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int IDW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  hsqrt_arbiter_if.slave bus
);
  localparam logic [IDW-1:0] c_LAST = IDW'(NREQ - 1);

  logic [IDW-1:0]  r_rr_ptr;
  logic [15:0]     r_sq_din;
  logic [LAT:0]    r_tag_v;
  logic [IDW-1:0]  r_tag_id [LAT+1];
  logic [NREQ-1:0] r_rsp_valid;
  logic [7:0]      r_rsp_data;
  logic [IDW-1:0]  r_rsp_id;
  logic [3:0]      r_inflight;

  logic            w_gnt_any;
  logic            w_hs;
  logic [IDW-1:0]  w_gnt_id;
  logic [15:0]     w_gnt_data;
  logic [NREQ-1:0] w_ready;
  logic [NREQ-1:0] w_tail_onehot;
  int              w_best_dist;
  int              w_dist;

  // Winner is the valid requester at the smallest wrapped distance from r_rr_ptr.
  always_comb begin
    w_gnt_any   = 1'b0;
    w_gnt_id    = '0;
    w_gnt_data  = 16'd0;
    w_best_dist = NREQ;
    w_dist      = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = i - int'(r_rr_ptr);
      if (w_dist < 0) w_dist = w_dist + NREQ;
      if (bus.req_valid[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_gnt_any   = 1'b1;
        w_gnt_id    = IDW'(i);
        w_gnt_data  = bus.req_data[16*i +: 16];
      end
    end
    w_hs = w_gnt_any & ~rst;
    for (int i = 0; i < NREQ; i++) begin
      w_ready[i]       = w_hs && (w_gnt_id == IDW'(i));
      w_tail_onehot[i] = (r_tag_id[LAT] == IDW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_sq_din    <= 16'd0;
      r_tag_v     <= '0;
      for (int s = 0; s <= LAT; s++) r_tag_id[s] <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= 8'd0;
      r_rsp_id    <= '0;
      r_inflight  <= 4'd0;
    end else begin
      if (w_hs) r_rr_ptr <= (w_gnt_id == c_LAST) ? '0 : w_gnt_id + 1'b1;
      r_sq_din    <= w_hs ? w_gnt_data : 16'd0;
      // Tags shift every cycle so the tail lines up with sq_dout of the same slot.
      r_tag_v     <= {r_tag_v[LAT-1:0], w_hs};
      r_tag_id[0] <= w_gnt_id;
      for (int s = 1; s <= LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
      if (r_tag_v[LAT]) begin
        r_rsp_valid <= w_tail_onehot;
        r_rsp_data  <= bus.sq_dout;
        r_rsp_id    <= r_tag_id[LAT];
      end else begin
        r_rsp_valid <= '0;
        r_rsp_data  <= 8'd0;
      end
      case ({w_hs, |r_rsp_valid})
        2'b10:   r_inflight <= r_inflight + 4'd1;
        2'b01:   r_inflight <= r_inflight - 4'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.sq_din    = r_sq_din;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.inflight  = r_inflight;

endmodule

`default_nettype wire

// File: tb/tb_hsqrt_arbiter.sv
// +------------------------------------------------------------------+
// | tb_hsqrt_arbiter: directed + random bench with behavioural model   |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_hsqrt_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int IDW  = 3;

  typedef struct { int due; int id; int data; } exp_t;
  typedef struct { int cyc; int id; int data; } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hsqrt_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  hsqrt_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Sqrt unit stand-in: LAT-deep delay line of floor(sqrt(sq_din)).
  logic [7:0] sq_pipe [LAT];
  always @(posedge clk) begin
    sq_pipe[0] <= 8'(isqrt(int'(bus.sq_din)));
    for (int k = 1; k < LAT; k++) sq_pipe[k] <= sq_pipe[k-1];
  end
  assign bus.sq_dout = sq_pipe[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;
  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: outstanding operands with their due cycles, plus own rr pointer.
  exp_t q[$];
  ev_t  glog[$];
  ev_t  rlog[$];
  int   cyc = 0;
  bit   armed = 1'b0;
  int   m_ptr = 0, m_last_id = 0, m_sqdin = 0;
  int   g, e_data, e_id;
  bit   e_due;
  logic [NREQ-1:0] e_valid, e_ready;

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      e_valid = '0; e_data = 0; e_id = m_last_id;
      e_due = (q.size() > 0) && (q[0].due == cyc);
      if (e_due) begin
        for (int i = 0; i < NREQ; i++) e_valid[i] = (i == q[0].id);
        e_data = q[0].data;
        e_id   = q[0].id;
      end
      check("rsp_valid", int'(bus.rsp_valid), int'(e_valid));
      check("rsp_data",  int'(bus.rsp_data), e_data);
      check("rsp_id",    int'(bus.rsp_id), e_id);
      check("inflight",  int'(bus.inflight), q.size());
      check("sq_din",    int'(bus.sq_din), m_sqdin);
      if (e_due) begin
        m_last_id = e_id;
        void'(q.pop_front());
      end
      g = -1;
      if (!rst)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      for (int i = 0; i < NREQ; i++) e_ready[i] = (i == g);
      check("req_ready", int'(bus.req_ready), int'(e_ready));
      if (g >= 0) begin
        m_sqdin = int'(bus.req_data[16*g +: 16]);
        q.push_back('{due: cyc + LAT + 2, id: g, data: isqrt(m_sqdin)});
        m_ptr = (g + 1) % NREQ;
      end else begin
        m_sqdin = 0;
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) glog.push_back('{cyc: cyc, id: i, data: 0});
    if (|bus.rsp_valid) rlog.push_back('{cyc: cyc, id: int'(bus.rsp_id), data: int'(bus.rsp_data)});
    if (rst) begin
      armed = 1'b1;
      q.delete();
      m_ptr = 0; m_last_id = 0; m_sqdin = 0;
    end
  end

  function automatic int g_id(input int k);  return (k < glog.size()) ? glog[k].id  : -1; endfunction
  function automatic int g_cyc(input int k); return (k < glog.size()) ? glog[k].cyc : -1; endfunction
  function automatic int r_id(input int k);  return (k < rlog.size()) ? rlog[k].id  : -1; endfunction
  function automatic int r_cyc(input int k); return (k < rlog.size()) ? rlog[k].cyc : -1; endfunction
  function automatic int r_dat(input int k); return (k < rlog.size()) ? rlog[k].data : -1; endfunction

  // Requester agents: v holds until handshake; keep re-raises valid immediately.
  logic [NREQ-1:0] v = '0, keep = '0, last_ready;
  logic [15:0]     d [NREQ];
  int gb, rb;
  int t2_exp [4] = '{0, 1, 255, 100};
  int t6_exp [3] = '{2, 3, 4};
  int t6_off [3] = '{LAT + 2, LAT + 4, LAT + 7};

  task automatic tick(input bit r);
    @(posedge clk); #1;
    rst = r;
    bus.req_valid = v;
    for (int i = 0; i < NREQ; i++) bus.req_data[16*i +: 16] = d[i];
    @(negedge clk); #1;
    last_ready = bus.req_ready;
    v = (v & ~(bus.req_valid & bus.req_ready)) | keep;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0);
  endtask

  task automatic do_reset();
    v = '0; keep = '0;
    tick(1'b1);
    tick(1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NREQ; i++) d[i] = 16'd0;
    tick(1'b1);
    tick(1'b0);
    check("reset_inflight", int'(bus.inflight), 0);
    check("reset_rsp_valid", int'(bus.rsp_valid), 0);

    // Single request 144 -> 12
    idle(2);
    gb = glog.size(); rb = rlog.size();
    v[1] = 1'b1; d[1] = 16'd144;
    tick(1'b0);
    check("t1_ready", int'(last_ready), 2);
    idle(LAT + 4);
    check("t1_grant_id", g_id(gb), 1);
    check("t1_rsp_count", rlog.size() - rb, 1);
    check("t1_rsp_data", r_dat(rb), 12);
    check("t1_rsp_id", r_id(rb), 1);
    check("t1_latency", r_cyc(rb) - g_cyc(gb), LAT + 2);

    // Simultaneous requests from all four
    do_reset();
    gb = glog.size(); rb = rlog.size();
    v = '1; d[0] = 16'd0; d[1] = 16'd1; d[2] = 16'd65535; d[3] = 16'd10000;
    idle(LAT + 8);
    for (int k = 0; k < 4; k++) begin
      check("t2_grant_id", g_id(gb + k), k);
      check("t2_grant_cyc", g_cyc(gb + k) - g_cyc(gb), k);
      check("t2_rsp_data", r_dat(rb + k), t2_exp[k]);
      check("t2_rsp_id", r_id(rb + k), k);
      check("t2_rsp_cyc", r_cyc(rb + k) - g_cyc(gb), LAT + 2 + k);
    end

    // Saturation fairness between 0 and 3
    do_reset();
    gb = glog.size();
    d[0] = 16'd7; d[3] = 16'd300;
    keep = 4'b1001; v = 4'b1001;
    idle(8);
    keep = '0;
    idle(LAT + 6);
    for (int k = 0; k < 8; k++) begin
      check("t3_grant_id", g_id(gb + k), (k % 2 == 0) ? 0 : 3);
      check("t3_grant_cyc", g_cyc(gb + k) - g_cyc(gb), k);
    end

    // Pointer wrap: grant 2 -> ptr 3, then only 0 -> ptr 1
    do_reset();
    gb = glog.size();
    v[2] = 1'b1; d[2] = 16'd50; tick(1'b0);
    v[0] = 1'b1; d[0] = 16'd60; tick(1'b0);
    v = 4'b0011; d[1] = 16'd70; tick(1'b0);
    idle(LAT + 4);
    check("t4_grant0", g_id(gb), 2);
    check("t4_grant1", g_id(gb + 1), 0);
    check("t4_grant2", g_id(gb + 2), 1);
    check("t4_grant3", g_id(gb + 3), 0);

    // Reset with three operands in flight
    do_reset();
    v = 4'b0111; d[0] = 16'd25; d[1] = 16'd36; d[2] = 16'd49;
    idle(3);
    rb = rlog.size();
    v = '0;
    tick(1'b1);
    idle(LAT + 4);
    check("t5_no_rsp", rlog.size() - rb, 0);
    check("t5_inflight", int'(bus.inflight), 0);
    gb = glog.size(); rb = rlog.size();
    v[2] = 1'b1; d[2] = 16'd400; tick(1'b0);
    idle(LAT + 4);
    check("t5_fresh_data", r_dat(rb), 20);
    check("t5_fresh_id", r_id(rb), 2);
    check("t5_fresh_lat", r_cyc(rb) - g_cyc(gb), LAT + 2);

    // Bubbles: issue on relative cycles 0, 2, 5
    do_reset();
    gb = glog.size(); rb = rlog.size();
    v[1] = 1'b1; d[1] = 16'd4;  tick(1'b0);
    idle(1);
    v[1] = 1'b1; d[1] = 16'd9;  tick(1'b0);
    idle(2);
    v[1] = 1'b1; d[1] = 16'd16; tick(1'b0);
    idle(LAT + 4);
    check("t6_rsp_count", rlog.size() - rb, 3);
    for (int k = 0; k < 3; k++) begin
      check("t6_rsp_data", r_dat(rb + k), t6_exp[k]);
      check("t6_rsp_cyc", r_cyc(rb + k) - g_cyc(gb), t6_off[k]);
    end

    // Randomised traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i] = 1'b1;
          case ($urandom_range(0, 5))
            0:       d[i] = 16'd0;
            1:       d[i] = 16'hFFFF;
            default: d[i] = 16'($urandom);
          endcase
        end
      tick($urandom_range(0, 199) == 0);
    end
    for (int n = 0; n < 4 * NREQ && v != '0; n++) tick(1'b0);
    idle(LAT + 4);
    check("rand_drain_valid", int'(v), 0);
    check("rand_drain_model", q.size(), 0);
    check("rand_drain_inflight", int'(bus.inflight), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
